// File: rtl/ls191_ctrl_pkg.sv
// Shared types for the ls191 counter-chain controller: command opcodes, FSM states
// and count-direction encodings.
package ls191_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'b00,
        START = 2'b01,
        STOP  = 2'b10,
        CFG   = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        SETTLE = 2'b10
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/ls191_slice.sv
// One 4-bit synchronous up/down counter slice with parallel load; counts only when
// both the local enable and the chained carry-in are high.
module ls191_slice
    import ls191_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic       dir,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout,
    output logic       tc
);

    // Terminal means "the next step in this direction wraps", so the carry ripples
    // to the next slice only when every lower slice is about to wrap.
    assign tc   = (dir == DIR_UP) ? (q == 4'hF) : (q == 4'h0);
    assign cout = cin & tc;

    // NOTE: sequential state is assigned with non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset)
            q <= 4'h0;
        else if (load)
            q <= load_val;
        else if (en && cin)
            q <= (dir == DIR_UP) ? q + 4'd1 : q - 4'd1;
    end

endmodule

// File: rtl/ls191_chain_ctrl.sv
// Command-driven sequencer for NIB cascaded ls191 slices forming one W-bit counter.
// Define LS191_PRESCALE_EN to add a 4-bit tick divider programmed by CFG.
module ls191_chain_ctrl
    import ls191_ctrl_pkg::*;
#(
    parameter int NIB = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [4*NIB-1:0] cmd_data,
    input  logic             dir,
    input  logic             tick,
    output logic [4*NIB-1:0] count,
    output logic             max_min,
    output logic             rco_n,
    output logic             done,
    output logic             running
);

    localparam int W = 4 * NIB;

    state_e         state;
    state_e         target;
    cmd_op_e        op;
    logic           dir_q;
    logic           auto_reload;
    logic [W-1:0]   reload_reg;
    logic           cmd_fire;
    logic           run_tick;
    logic           counted;
    logic           terminal;
    logic           slice_load;
    logic [W-1:0]   load_val;
    logic [NIB:0]   carry;
    logic [NIB-1:0] slice_tc;

    assign op       = cmd_op_e'(cmd_op);
    assign cmd_fire = cmd_valid && cmd_ready;
    // An accepted command always wins over a coincident tick.
    assign run_tick = (state == RUN) && tick && !cmd_fire;

`ifdef LS191_PRESCALE_EN
    logic [3:0] prescale;
    logic [3:0] div;

    assign counted = run_tick && (div == prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= 4'h0;
            div      <= 4'h0;
        end else begin
            if (cmd_fire && op == CFG)
                prescale <= cmd_data[4:1];
            if (cmd_fire && (op == LOAD || op == START))
                div <= 4'h0;
            else if (run_tick)
                div <= counted ? 4'h0 : div + 4'd1;
        end
    end
`else
    assign counted = run_tick;
`endif

    // The counted tick enters as carry[0]; it survives the whole chain only when every
    // slice is terminal, so the final carry-out is exactly the terminal tick.
    assign carry[0]   = counted;
    assign terminal   = carry[NIB];
    assign max_min    = &slice_tc;
    assign slice_load = (cmd_fire && op == LOAD) || (terminal && auto_reload);
    assign load_val   = cmd_fire ? cmd_data : reload_reg;

    for (genvar i = 0; i < NIB; i++) begin : g_slice
        ls191_slice u_slice (
            .clk      (clk),
            .reset    (reset),
            .load     (slice_load),
            .load_val (load_val[4*i +: 4]),
            .en       (!terminal),
            .dir      (dir_q),
            .cin      (carry[i]),
            .q        (count[4*i +: 4]),
            .cout     (carry[i+1]),
            .tc       (slice_tc[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            target      <= IDLE;
            dir_q       <= DIR_UP;
            auto_reload <= 1'b0;
            reload_reg  <= '0;
            cmd_ready   <= 1'b1;
            rco_n       <= 1'b1;
            done        <= 1'b0;
            running     <= 1'b0;
        end else begin
            rco_n <= !terminal;
            done  <= terminal && !auto_reload;
            case (state)
                SETTLE: begin
                    state     <= target;
                    cmd_ready <= 1'b1;
                    running   <= (target == RUN);
                end
                default: begin
                    if (cmd_fire) begin
                        state     <= SETTLE;
                        cmd_ready <= 1'b0;
                        running   <= 1'b0;
                        case (op)
                            LOAD: begin
                                reload_reg <= cmd_data;
                                target     <= state;
                            end
                            START: begin
                                dir_q  <= dir;
                                target <= RUN;
                            end
                            STOP: target <= IDLE;
                            CFG: begin
                                auto_reload <= cmd_data[0];
                                target      <= state;
                            end
                            default: target <= state;
                        endcase
                    end else if (terminal && !auto_reload) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ls191_chain_ctrl.md
Name: ls191_chain_ctrl

Overview:
Controller and sequencer for a cascade of 4-bit synchronous up/down counter slices, giving one W-bit presettable counter.
- A command interface loads, starts, stops and configures the counter.
- The block generates terminal-count (max/min), ripple-carry and done indications.
- Consumers are the video timing and object-position logic, which share one command port to preset and run the counter.

Parameters:
NIB, 2, number of cascaded 4-bit slices; counter width W = 4*NIB.

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
cmd_op  in  2  00 LOAD, 01 START, 10 STOP, 11 CFG.
cmd_data  in  W  LOAD: preset value. CFG: bit0 auto_reload, bits[4:1] prescale.
dir  in  1  0 = up, 1 = down; sampled only on START.
tick  in  1  count strobe (one-cycle enable).
count  out  W  current counter value.
max_min  out  1  count == all-ones with up dir, or count == 0 with down dir (latched dir); combinational.
rco_n  out  1  active-low ripple output, registered.
done  out  1  one-cycle pulse when a one-shot run terminates.
running  out  1  high in RUN.

Behaviour:
Reset values: count=0, dir_q=0, auto_reload=0, reload_reg=0, prescale=0, state=IDLE, cmd_ready=1, rco_n=1, done=0, running=0.

States: IDLE, RUN, SETTLE.
- SETTLE lasts exactly one cycle after any accepted command. cmd_ready=0 in SETTLE, 1 otherwise.
- On leaving SETTLE the block goes to the target state the command selected.
- Ticks during SETTLE are ignored.

Commands (take effect on the accepting edge):
- LOAD: count <= cmd_data; reload_reg <= cmd_data; target = prior state (IDLE or RUN).
- START: dir_q <= dir; target RUN. START while already RUN re-latches dir only.
- STOP: target IDLE; count holds.
- CFG: auto_reload and prescale latched; target = prior state.

Counting:
- Counting happens in RUN on tick, when no command is accepted that cycle (command wins over tick).
- Up: count+1. Down: count-1. Modulo 2^W, with carry chained slice to slice.
- Terminal tick: a counted tick while max_min=1.
  - auto_reload=1: count <= reload_reg, stay RUN.
  - auto_reload=0: count holds at terminal value, state -> IDLE, done=1 next cycle.
- rco_n=0 for exactly the cycle after any terminal tick, 1 otherwise.
- IDLE ignores tick; max_min is still valid in IDLE.
- Reset asserted mid-run returns every register to its reset value on that edge, and drops any pending command.

Optional Feature:
LS191_PRESCALE_EN.
- Defined: a 4-bit prescale counter divides tick. A counted tick occurs on every (prescale+1)th tick in RUN. The divider clears on START, LOAD and reset.
- Undefined: the divider is absent, cmd_data[4:1] is ignored on CFG, and every tick in RUN counts.

Decomposition:
- Package ls191_ctrl_pkg holds:
  - cmd_op_e enum (LOAD/START/STOP/CFG);
  - state_e enum (IDLE/RUN/SETTLE);
  - localparam encodings for DIR_UP and DIR_DOWN.
- Sub-module ls191_slice: one 4-bit up/down slice with load, count enable, carry-in, carry-out and terminal flag. It is instantiated NIB times via generate, with carry-out feeding the next carry-in.

Test Plan:
- Reset then LOAD 8'hFD, START dir=0, 3 ticks -> count FE, FF, FF with max_min=1. Third tick: rco_n=0 one cycle, done=1 one cycle, running=0.
- CFG auto_reload=1, LOAD 8'h02, START dir=1, 3 ticks -> count 01, 00, 02; rco_n low once; done stays 0; running stays 1.
- STOP accepted in the same cycle as tick at count 8'h10 -> count stays 10, state IDLE, cmd_ready=0 for one cycle; later ticks ignored.
- LOAD 8'h40 while RUN, tick during the SETTLE cycle -> count=40 and tick ignored; next tick gives 41.
- reset asserted mid-RUN at count 8'h7A -> next cycle count=0, rco_n=1, done=0, cmd_ready=1, IDLE.
- With LS191_PRESCALE_EN: CFG prescale=2, LOAD 0, START up, 6 ticks -> count=2. Without the macro -> count=6.
